serial_deframer: RTL

Receive-side companion to the SISO DFF shift register. It samples the serial bit stream from the shift register output, frames it into WIDTH-bit words on a start-of-frame marker, and holds each completed word in a one-entry output register. Words leave through a valid/ready handshake, and the block reports dropped words and aborted frames with sticky flags.

---
 rtl/serial_pkg.sv | 19 +
 rtl/word_hold.sv | 57 +++++
 rtl/serial_deframer.sv | 135 +++++++++++++
 3 files changed

// File: rtl/serial_pkg.sv
// serial_pkg: shared definitions for the serial receive path.
//   SER_WIDTH_DEF   - default word width
//   deframe_state_t - deframer FSM states
//   cnt_w()         - bit-counter width for a given word width
package serial_pkg;

    localparam int unsigned SER_WIDTH_DEF = 8;

    typedef enum logic [0:0] {
        DF_IDLE,
        DF_SHIFT
    } deframe_state_t;

    // The counter must be able to hold the value `width`.
    function automatic int unsigned cnt_w(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/word_hold.sv
// word_hold: one-entry valid/ready holding register.
// Ports:
//   clk_i, rst_ni  - clock, async active-low reset
//   load_i, din_i  - offer a new word
//   dout_o         - held word, stable while valid_o is high and not accepted
//   valid_o        - a word is held
//   ready_i        - consumer accepts the word when valid_o & ready_i
//   overrun_o      - combinational pulse: the offered word was dropped
module word_hold #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [Width-1:0] din_i,
    output logic [Width-1:0] dout_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             overrun_o
);

    logic [Width-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             can_load;

    // Space exists if empty, or if the current word leaves on this edge.
    assign can_load = ~valid_q | ready_i;

    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_o = 1'b0;
        if (load_i && can_load) begin
            data_d  = din_i;
            valid_d = 1'b1;
        end else begin
            if (valid_q && ready_i) begin
                valid_d = 1'b0;
            end
            overrun_o = load_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign dout_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/serial_deframer.sv
// serial_deframer: frames a qualified serial bit stream into MSB-first words.
// Ports:
//   clk_i, rst_ni  - clock, async active-low reset
//   sin_i          - serial data bit
//   sin_en_i       - qualifies sin_i
//   sof_i          - start of frame, qualified by sin_en_i
//   word_out_o     - held word (first bit received lands in the MSB)
//   word_valid_o   - word_out_o holds an unconsumed word
//   word_ready_i   - consumer accepts on word_valid_o & word_ready_i
//   overrun_o      - sticky: a completed word was dropped
//   frame_err_o    - sticky: a frame was aborted by sof mid-word
//   clr_err_i      - synchronous clear of both sticky flags (a set wins)
module serial_deframer
    import serial_pkg::*;
#(
    parameter int unsigned WIDTH = SER_WIDTH_DEF
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             sin_i,
    input  logic             sin_en_i,
    input  logic             sof_i,
    output logic [WIDTH-1:0] word_out_o,
    output logic             word_valid_o,
    input  logic             word_ready_i,
    output logic             overrun_o,
    output logic             frame_err_o,
    input  logic             clr_err_i
);

    localparam int unsigned CntW = cnt_w(WIDTH);

    deframe_state_t   state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    // Only WIDTH-1 bits are stored; the completing bit goes straight to the holder.
    logic [WIDTH-2:0] shift_q, shift_d;
    logic             overrun_q, overrun_d;
    logic             frame_err_q, frame_err_d;

    logic             word_load;
    logic [WIDTH-1:0] word_new;
    logic             abort;
    logic             drop;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        word_load = 1'b0;
        word_new  = {shift_q, sin_i};
        abort     = 1'b0;
        case (state_q)
            DF_IDLE: begin
                if (sin_en_i && sof_i) begin
                    shift_d    = '0;
                    shift_d[0] = sin_i;
                    cnt_d      = CntW'(1);
                    state_d    = DF_SHIFT;
                end
            end
            DF_SHIFT: begin
                if (sin_en_i) begin
                    if (cnt_q == CntW'(WIDTH - 1)) begin
                        // Completing bit: sof on it is ignored.
                        word_load = 1'b1;
                        cnt_d     = '0;
                        shift_d   = '0;
                        state_d   = DF_IDLE;
                    end else if (sof_i) begin
                        abort      = 1'b1;
                        shift_d    = '0;
                        shift_d[0] = sin_i;
                        cnt_d      = CntW'(1);
                    end else begin
                        shift_d    = shift_q << 1;
                        shift_d[0] = sin_i;
                        cnt_d      = cnt_q + CntW'(1);
                    end
                end
            end
            default: begin
                state_d = DF_IDLE;
            end
        endcase
    end

    word_hold #(
        .Width (WIDTH)
    ) u_word_hold (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .load_i    (word_load),
        .din_i     (word_new),
        .dout_o    (word_out_o),
        .valid_o   (word_valid_o),
        .ready_i   (word_ready_i),
        .overrun_o (drop)
    );

    // Sticky flags: clear first, then a same-edge set overrides it.
    always_comb begin
        overrun_d   = overrun_q;
        frame_err_d = frame_err_q;
        if (clr_err_i) begin
            overrun_d   = 1'b0;
            frame_err_d = 1'b0;
        end
        if (drop) begin
            overrun_d = 1'b1;
        end
        if (abort) begin
            frame_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= DF_IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign overrun_o   = overrun_q;
    assign frame_err_o = frame_err_q;

endmodule
